// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter for the single register-file write port of a PE.
// One output stage holds the granted write and supplies RAW hazard/bypass info.
module regfile_wr_arbiter #(
  parameter int NREQ   = 4,
  parameter int AWIDTH = 3,
  parameter int DWIDTH = 32
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       Flush,
  input  logic                       Hold,
  input  logic [NREQ-1:0]            Req_Valid,
  input  logic [NREQ*AWIDTH-1:0]     Req_Addr,
  input  logic [NREQ*DWIDTH-1:0]     Req_Data,
  output logic [NREQ-1:0]            Req_Ready,
  output logic                       Rf_Write_En,
  output logic [AWIDTH-1:0]          Rf_Write_Addr,
  output logic [DWIDTH-1:0]          Rf_Write_Data,
  input  logic [AWIDTH-1:0]          Rd_Addr0,
  input  logic [AWIDTH-1:0]          Rd_Addr1,
  output logic                       Rd_Hazard0,
  output logic                       Rd_Hazard1,
  output logic [DWIDTH-1:0]          Bypass_Data,
  output logic [$clog2(NREQ)-1:0]    Grant_Id,
  output logic [15:0]                Conflict_Cnt
);
  localparam int PW = $clog2(NREQ);

  logic [NREQ-1:0][AWIDTH-1:0] req_addr;
  logic [NREQ-1:0][DWIDTH-1:0] req_data;

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign req_addr[i] = Req_Addr[i*AWIDTH +: AWIDTH];
    assign req_data[i] = Req_Data[i*DWIDTH +: DWIDTH];
  end

  logic              stg_valid_q, stg_valid_d;
  logic [AWIDTH-1:0] stg_addr_q, stg_addr_d;
  logic [DWIDTH-1:0] stg_data_q, stg_data_d;
  logic [PW-1:0]     grant_id_q, grant_id_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [15:0]       cnt_q, cnt_d;

  logic [NREQ-1:0]   ready;
  logic [PW-1:0]     win;
  logic              xfer;
  logic              multi;
  int                idx;

  // Search from ptr_q upward, wrapping; the first valid index wins.
  always_comb begin
    ready = '0;
    win   = ptr_q;
    xfer  = 1'b0;
    idx   = 0;
    if (!Hold && !Flush) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = int'(ptr_q) + k;
        if (idx >= NREQ) idx = idx - NREQ;
        if (!xfer && Req_Valid[idx]) begin
          xfer = 1'b1;
          win  = PW'(idx);
        end
      end
    end
    if (xfer) ready[win] = 1'b1;
  end

  // Two or more valid bits: clearing the lowest set bit leaves something.
  assign multi = |(Req_Valid & (Req_Valid - 1'b1));

  always_comb begin
    stg_valid_d = stg_valid_q;
    stg_addr_d  = stg_addr_q;
    stg_data_d  = stg_data_q;
    grant_id_d  = grant_id_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    if (Flush) begin
      stg_valid_d = 1'b0;
      ptr_d       = '0;
      cnt_d       = '0;
    end else if (xfer) begin
      stg_valid_d = 1'b1;
      stg_addr_d  = req_addr[win];
      stg_data_d  = req_data[win];
      grant_id_d  = win;
      ptr_d       = (win == PW'(NREQ-1)) ? '0 : win + 1'b1;
      if (multi && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
    end else if (!Hold) begin
      stg_valid_d = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      stg_valid_q <= 1'b0;
      stg_addr_q  <= '0;
      stg_data_q  <= '0;
      grant_id_q  <= '0;
      ptr_q       <= '0;
      cnt_q       <= '0;
    end else begin
      stg_valid_q <= stg_valid_d;
      stg_addr_q  <= stg_addr_d;
      stg_data_q  <= stg_data_d;
      grant_id_q  <= grant_id_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
    end
  end

  assign Req_Ready     = ready;
  assign Rf_Write_En   = stg_valid_q & ~Hold;
  assign Rf_Write_Addr = stg_addr_q;
  assign Rf_Write_Data = stg_data_q;
  assign Bypass_Data   = stg_data_q;
  // Hazards ignore Hold: a held write has still not reached the file.
  assign Rd_Hazard0    = stg_valid_q & (Rd_Addr0 == stg_addr_q);
  assign Rd_Hazard1    = stg_valid_q & (Rd_Addr1 == stg_addr_q);
  assign Grant_Id      = grant_id_q;
  assign Conflict_Cnt  = cnt_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter: inputs change on the falling edge,
// outputs are sampled on the falling edge or 1 time unit after an input change.
module tb_regfile_wr_arbiter;
  localparam int NREQ = 4, AW = 3, DW = 32;

  logic              Clk = 1'b0;
  logic              Reset, Flush, Hold;
  logic [NREQ-1:0]   Req_Valid;
  logic [NREQ*AW-1:0] Req_Addr;
  logic [NREQ*DW-1:0] Req_Data;
  logic [NREQ-1:0]   Req_Ready;
  logic              Rf_Write_En;
  logic [AW-1:0]     Rf_Write_Addr;
  logic [DW-1:0]     Rf_Write_Data;
  logic [AW-1:0]     Rd_Addr0, Rd_Addr1;
  logic              Rd_Hazard0, Rd_Hazard1;
  logic [DW-1:0]     Bypass_Data;
  logic [1:0]        Grant_Id;
  logic [15:0]       Conflict_Cnt;

  int n_chk = 0;
  int n_err = 0;

  always #5 Clk = ~Clk;

  regfile_wr_arbiter #(.NREQ(NREQ), .AWIDTH(AW), .DWIDTH(DW)) dut (
    .Clk(Clk), .Reset(Reset), .Flush(Flush), .Hold(Hold),
    .Req_Valid(Req_Valid), .Req_Addr(Req_Addr), .Req_Data(Req_Data),
    .Req_Ready(Req_Ready), .Rf_Write_En(Rf_Write_En),
    .Rf_Write_Addr(Rf_Write_Addr), .Rf_Write_Data(Rf_Write_Data),
    .Rd_Addr0(Rd_Addr0), .Rd_Addr1(Rd_Addr1),
    .Rd_Hazard0(Rd_Hazard0), .Rd_Hazard1(Rd_Hazard1),
    .Bypass_Data(Bypass_Data), .Grant_Id(Grant_Id), .Conflict_Cnt(Conflict_Cnt)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    Req_Addr[i*AW +: AW] = a;
    Req_Data[i*DW +: DW] = d;
  endtask

  initial begin
    Reset = 1'b0; Flush = 1'b0; Hold = 1'b0;
    Req_Valid = '0; Req_Addr = '0; Req_Data = '0;
    Rd_Addr0 = '0; Rd_Addr1 = '0;

    // Reset state; Ready already follows Valid with Ptr=0
    set_req(0, 3'd3, 32'hA5A5_A5A5);
    Req_Valid = 4'b0001;
    #1;
    chk("rst_we", Rf_Write_En, 0);
    chk("rst_haz0", Rd_Hazard0, 0);
    chk("rst_haz1", Rd_Hazard1, 0);
    chk("rst_byp", Bypass_Data, 0);
    chk("rst_gid", Grant_Id, 0);
    chk("rst_cnt", Conflict_Cnt, 0);
    chk("rst_ready", Req_Ready, 4'b0001);
    #5 Reset = 1'b1;

    // Single write from requester 0
    @(negedge Clk);
    chk("t1_ready", Req_Ready, 4'b0001);
    @(negedge Clk);
    Req_Valid = '0; Rd_Addr0 = 3'd3;
    #1;
    chk("t1_we", Rf_Write_En, 1);
    chk("t1_addr", Rf_Write_Addr, 3);
    chk("t1_data", Rf_Write_Data, 32'hA5A5_A5A5);
    chk("t1_byp", Bypass_Data, 32'hA5A5_A5A5);
    chk("t1_gid", Grant_Id, 0);
    chk("t1_haz0", Rd_Hazard0, 1);
    @(negedge Clk);
    chk("t1_idle_we", Rf_Write_En, 0);
    chk("t1_idle_haz0", Rd_Hazard0, 0);

    // Flush to Ptr=0, then all four valid for 8 cycles
    Flush = 1'b1;
    @(negedge Clk);
    Flush = 1'b0;
    for (int i = 0; i < NREQ; i++) set_req(i, AW'(i), 32'h1000_0000 + i);
    Req_Valid = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      #1 chk("rr_ready", Req_Ready, 32'(1) << (c % 4));
      @(negedge Clk);
      chk("rr_we", Rf_Write_En, 1);
      chk("rr_gid", Grant_Id, c % 4);
      chk("rr_addr", Rf_Write_Addr, c % 4);
      chk("rr_data", Rf_Write_Data, 32'h1000_0000 + (c % 4));
    end
    Req_Valid = '0;
    #1 chk("rr_cnt", Conflict_Cnt, 8);
    @(negedge Clk);

    // Sparse requesters 1 and 3, Ptr back at 0
    Req_Valid = 4'b1010;
    for (int c = 0; c < 6; c++) begin
      #1 chk("sp_ready", Req_Ready, (c % 2 == 0) ? 4'b0010 : 4'b1000);
      @(negedge Clk);
      chk("sp_gid", Grant_Id, (c % 2 == 0) ? 1 : 3);
    end
    Req_Valid = '0;
    #1 chk("sp_cnt", Conflict_Cnt, 14);
    @(negedge Clk);

    // Transfer from requester 2, then Hold for 3 cycles
    set_req(2, 3'd5, 32'hDEAD_BEEF);
    Req_Valid = 4'b0100;
    #1 chk("hd_ready", Req_Ready, 4'b0100);
    @(negedge Clk);
    Hold = 1'b1; Req_Valid = 4'b0001; Rd_Addr1 = 3'd5;
    for (int h = 0; h < 3; h++) begin
      #1;
      chk("hd_we", Rf_Write_En, 0);
      chk("hd_ready0", Req_Ready, 0);
      chk("hd_addr", Rf_Write_Addr, 5);
      chk("hd_data", Rf_Write_Data, 32'hDEAD_BEEF);
      chk("hd_haz1", Rd_Hazard1, 1);
      @(negedge Clk);
    end
    Hold = 1'b0; Req_Valid = '0;
    #1;
    chk("hd_rel_we", Rf_Write_En, 1);
    chk("hd_rel_addr", Rf_Write_Addr, 5);
    chk("hd_rel_data", Rf_Write_Data, 32'hDEAD_BEEF);
    chk("hd_rel_cnt", Conflict_Cnt, 14);
    @(negedge Clk);
    chk("hd_after_we", Rf_Write_En, 0);
    chk("hd_after_gid", Grant_Id, 2);

    // Ptr=3: grant requester 1 -> Ptr=2, then Flush with the stage valid
    Req_Valid = 4'b0010;
    #1 chk("fl_pre_ready", Req_Ready, 4'b0010);
    @(negedge Clk);
    Flush = 1'b1; Req_Valid = 4'b1111;
    #1;
    chk("fl_ready", Req_Ready, 0);
    chk("fl_we", Rf_Write_En, 1);
    chk("fl_gid", Grant_Id, 1);
    @(negedge Clk);
    Flush = 1'b0;
    #1;
    chk("fl_post_we", Rf_Write_En, 0);
    chk("fl_post_cnt", Conflict_Cnt, 0);
    chk("fl_post_ready", Req_Ready, 4'b0001);

    // Reset while the stage is valid and held
    @(negedge Clk);
    Hold = 1'b1; Req_Valid = '0; Rd_Addr0 = 3'd0;
    #1;
    chk("ra_pre_we", Rf_Write_En, 0);
    chk("ra_pre_haz0", Rd_Hazard0, 1);
    chk("ra_pre_cnt", Conflict_Cnt, 1);
    #2 Reset = 1'b0;
    #1;
    chk("ra_we", Rf_Write_En, 0);
    chk("ra_haz0", Rd_Hazard0, 0);
    chk("ra_cnt", Conflict_Cnt, 0);
    #2 Reset = 1'b1; Hold = 1'b0;
    @(negedge Clk);
    chk("ra_post_we0", Rf_Write_En, 0);
    @(negedge Clk);
    chk("ra_post_we1", Rf_Write_En, 0);

    // Saturate Conflict_Cnt with continuous contention
    Req_Valid = 4'b1111;
    repeat (65534) @(negedge Clk);
    chk("sat_fffe", Conflict_Cnt, 16'hFFFE);
    chk("sat_we", Rf_Write_En, 1);
    @(negedge Clk);
    chk("sat_ffff", Conflict_Cnt, 16'hFFFF);
    repeat (5) @(negedge Clk);
    chk("sat_hold", Conflict_Cnt, 16'hFFFF);
    Req_Valid = '0;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
